// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one prefetch in flight to a
// variable-latency instruction memory and presents instructions to decode.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic                  instr_ready,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PREFETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [DATA_WIDTH-1:0] redirect_pc, redirect_pc_nxt;
    logic [DATA_WIDTH-1:0] skid_instr, skid_instr_nxt;
    logic [DATA_WIDTH-1:0] skid_pc, skid_pc_nxt;
    logic [DATA_WIDTH-1:0] instr_nxt, pc_nxt;
    logic                  instr_valid_nxt;

    logic                  accept;
    logic [DATA_WIDTH-1:0] seq_pc;
    logic [DATA_WIDTH-1:0] target;

    assign accept    = instr_valid & instr_ready;
    assign seq_pc    = fetch_pc + DATA_WIDTH'(4);
    assign target    = pc + ImmOp;
    assign imem_addr = fetch_pc;
    assign imem_req  = (state == FETCH) || (state == PREFETCH) || (state == DISCARD);

    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        redirect_pc_nxt = redirect_pc;
        skid_instr_nxt  = skid_instr;
        skid_pc_nxt     = skid_pc;
        instr_nxt       = instr;
        pc_nxt          = pc;
        instr_valid_nxt = instr_valid;

        case (state)
            IDLE: state_nxt = FETCH;

            FETCH: begin
                if (imem_ack) begin
                    instr_nxt       = imem_rdata;
                    pc_nxt          = fetch_pc;
                    instr_valid_nxt = 1'b1;
                    fetch_pc_nxt    = seq_pc;
                    state_nxt       = PREFETCH;
                end
            end

            PREFETCH: begin
                if (accept) begin
                    if (PCsrc) begin
                        instr_valid_nxt = 1'b0;
                        if (imem_ack) begin
                            fetch_pc_nxt = target;
                            state_nxt    = FETCH;
                        end else begin
                            // Request still pending: address must not move until it completes.
                            redirect_pc_nxt = target;
                            state_nxt       = DISCARD;
                        end
                    end else if (imem_ack) begin
                        instr_nxt    = imem_rdata;
                        pc_nxt       = fetch_pc;
                        fetch_pc_nxt = seq_pc;
                    end else begin
                        instr_valid_nxt = 1'b0;
                        state_nxt       = FETCH;
                    end
                end else if (imem_ack) begin
                    skid_instr_nxt = imem_rdata;
                    skid_pc_nxt    = fetch_pc;
                    fetch_pc_nxt   = seq_pc;
                    state_nxt      = HOLD;
                end
            end

            HOLD: begin
                if (accept) begin
                    if (PCsrc) begin
                        instr_valid_nxt = 1'b0;
                        fetch_pc_nxt    = target;
                        state_nxt       = FETCH;
                    end else begin
                        instr_nxt = skid_instr;
                        pc_nxt    = skid_pc;
                        state_nxt = PREFETCH;
                    end
                end
            end

            DISCARD: begin
                if (imem_ack) begin
                    fetch_pc_nxt = redirect_pc;
                    state_nxt    = FETCH;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            redirect_pc <= RESET_PC;
            skid_instr  <= '0;
            skid_pc     <= '0;
            instr       <= '0;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            redirect_pc <= redirect_pc_nxt;
            skid_instr  <= skid_instr_nxt;
            skid_pc     <= skid_pc_nxt;
            instr       <= instr_nxt;
            pc          <= pc_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: architectural stream model checked every cycle, plus
// directed scenarios with hand-computed cycle-exact expectations.
module tb_fetch_unit;

    localparam logic [31:0] K      = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready, PCsrc;
    logic [31:0] instr, pc, ImmOp;

    logic        w_req, w_ack, w_valid, w_ready, w_pcsrc;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_imm;

    int n_checks = 0;
    int n_fail   = 0;

    int mem_lat;
    int wait_cnt;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmOp(ImmOp)
    );

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr(w_instr), .pc(w_pc),
        .instr_ready(w_ready), .PCsrc(w_pcsrc), .ImmOp(w_imm)
    );

    // Memory: word at address a is a ^ K; ack after mem_lat waiting cycles, abandoned on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_addr ^ K;

    assign w_ack   = w_req;
    assign w_rdata = w_addr ^ K;
    assign w_ready = 1'b1;
    assign w_pcsrc = 1'b0;
    assign w_imm   = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: the program-order stream decode must see.
    logic [31:0] m_exp_pc, m_hold_pc, m_hold_instr;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_exp_pc     = 32'h0;
            m_hold_pc    = 32'h0;
            m_hold_instr = 32'h0;
        end else if (instr_valid) begin
            check("model_pc", pc, m_exp_pc);
            check("model_instr", instr, m_exp_pc ^ K);
            m_hold_pc    = m_exp_pc;
            m_hold_instr = m_exp_pc ^ K;
            if (instr_ready)
                m_exp_pc = PCsrc ? m_exp_pc + ImmOp : m_exp_pc + 32'd4;
        end else begin
            check("hold_pc", pc, m_hold_pc);
            check("hold_instr", instr, m_hold_instr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n       = 1'b0;
        mem_lat     = 0;
        instr_ready = 1'b1;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        repeat (2) tick();
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_w_pc", w_pc, WRAP_PC);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        mem_lat     = 0;
        instr_ready = 1'b1;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        #1;

        // A: zero-wait stream, plus the wrapping instance
        do_reset();
        tick();
        check("a_req_e1", {31'b0, imem_req}, 32'h1);
        check("a_addr_e1", imem_addr, 32'h0);
        check("a_valid_e1", {31'b0, instr_valid}, 32'h0);
        tick();
        check("a_valid_e2", {31'b0, instr_valid}, 32'h1);
        check("a_pc_e2", pc, 32'h0);
        check("a_instr_e2", instr, 32'hA5A5_0000);
        check("a_addr_e2", imem_addr, 32'h4);
        check("w_pc_e2", w_pc, 32'hFFFF_FFF8);
        check("w_instr_e2", w_instr, 32'h5A5A_FFF8);
        tick();
        check("a_pc_e3", pc, 32'h4);
        check("a_instr_e3", instr, 32'hA5A5_0004);
        check("w_pc_e3", w_pc, 32'hFFFF_FFFC);
        tick();
        check("a_pc_e4", pc, 32'h8);
        check("a_valid_e4", {31'b0, instr_valid}, 32'h1);
        check("w_pc_e4", w_pc, 32'h0000_0000);
        check("w_instr_e4", w_instr, 32'hA5A5_0000);

        // B: backpressure fills the skid, then drains without gaps
        do_reset();
        instr_ready = 1'b0;
        repeat (2) tick();
        check("b_pc_e2", pc, 32'h0);
        check("b_req_e2", {31'b0, imem_req}, 32'h1);
        for (int e = 3; e <= 7; e++) begin
            tick();
            check("b_req_hold", {31'b0, imem_req}, 32'h0);
            check("b_pc_hold", pc, 32'h0);
            check("b_valid_hold", {31'b0, instr_valid}, 32'h1);
        end
        instr_ready = 1'b1;
        tick();
        check("b_pc_e8", pc, 32'h4);
        check("b_valid_e8", {31'b0, instr_valid}, 32'h1);
        tick();
        check("b_pc_e9", pc, 32'h8);
        check("b_valid_e9", {31'b0, instr_valid}, 32'h1);

        // C: taken branch with the prefetch acked in the accept cycle
        do_reset();
        repeat (4) tick();
        check("c_pc_e4", pc, 32'h8);
        PCsrc = 1'b1;
        ImmOp = 32'hFFFF_FFF8;
        tick();
        PCsrc = 1'b0;
        ImmOp = 32'h0;
        check("c_bubble", {31'b0, instr_valid}, 32'h0);
        check("c_addr_tgt", imem_addr, 32'h0);
        tick();
        check("c_valid_e6", {31'b0, instr_valid}, 32'h1);
        check("c_pc_e6", pc, 32'h0);
        tick();
        check("c_pc_e7", pc, 32'h4);

        // D: branch while the prefetch is slow
        do_reset();
        repeat (3) tick();
        check("d_pc_e3", pc, 32'h4);
        mem_lat = 3;
        PCsrc   = 1'b1;
        ImmOp   = 32'h40;
        tick();
        PCsrc = 1'b0;
        ImmOp = 32'h0;
        check("d_valid_e4", {31'b0, instr_valid}, 32'h0);
        check("d_addr_e4", imem_addr, 32'h8);
        check("d_req_e4", {31'b0, imem_req}, 32'h1);
        tick();
        check("d_addr_e5", imem_addr, 32'h8);
        tick();
        check("d_addr_e6", imem_addr, 32'h8);
        check("d_ack_e6", {31'b0, imem_ack}, 32'h1);
        tick();
        check("d_addr_e7", imem_addr, 32'h44);
        check("d_valid_e7", {31'b0, instr_valid}, 32'h0);
        mem_lat = 0;
        tick();
        check("d_valid_e8", {31'b0, instr_valid}, 32'h1);
        check("d_pc_e8", pc, 32'h44);
        check("d_instr_e8", instr, 32'hA5A5_0044);

        // E: reset pulsed in DISCARD while an ack is pending
        do_reset();
        repeat (3) tick();
        mem_lat = 3;
        PCsrc   = 1'b1;
        ImmOp   = 32'h40;
        tick();
        PCsrc = 1'b0;
        ImmOp = 32'h0;
        repeat (2) tick();
        check("e_ack_pending", {31'b0, imem_ack}, 32'h1);
        check("e_pc_before", pc, 32'h4);
        rst_n = 1'b0;
        #1;
        check("e_req_async", {31'b0, imem_req}, 32'h0);
        check("e_addr_async", imem_addr, 32'h0);
        check("e_pc_async", pc, 32'h0);
        check("e_instr_async", instr, 32'h0);
        check("e_ack_dropped", {31'b0, imem_ack}, 32'h0);
        mem_lat = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("e_addr_e1", imem_addr, 32'h0);
        check("e_valid_e1", {31'b0, instr_valid}, 32'h0);
        tick();
        check("e_pc_e2", pc, 32'h0);
        check("e_instr_e2", instr, 32'hA5A5_0000);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the register-file/ALU/data-memory datapath. It owns the program counter and issues word requests to a variable-latency instruction memory. It presents each fetched instruction and its PC to decode through a valid/ready handshake. When an instruction is accepted with PCsrc set, it redirects fetch to pc + ImmOp and discards any wrong-path word. One prefetch request may be outstanding, plus a one-entry skid buffer, so a zero-wait memory sustains one instruction per cycle.

## Interface
- DATA_WIDTH, 32, width of instructions, PCs and immediates
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  request valid; held until imem_ack
- imem_addr  output  DATA_WIDTH  request byte address; stable while imem_req=1 and imem_ack=0
- imem_ack  input  1  request complete this cycle; may be asserted in the same cycle imem_req rises
- imem_rdata  input  DATA_WIDTH  instruction word, valid with imem_ack
- instr_valid  output  1  instr/pc hold a valid instruction
- instr  output  DATA_WIDTH  instruction to decode
- pc  output  DATA_WIDTH  address of instr
- instr_ready  input  1  decode accepts; accept = instr_valid & instr_ready
- PCsrc  input  1  sampled only on accept: take the branch (branch & eq from the datapath)
- ImmOp  input  DATA_WIDTH  sampled only on accept: branch offset, already sign-extended

## Operation
- Registers: fetch_pc, redirect_pc, out regs (instr, pc, instr_valid), skid regs (skid_instr, skid_pc), state.
- imem_addr = fetch_pc. imem_req = 1 in FETCH, PREFETCH and DISCARD; 0 in IDLE and HOLD. An imem_ack while imem_req=0 is a protocol error (bench assertion); the block ignores it.
- Target = pc + ImmOp, modulo 2^DATA_WIDTH. Low bits pass through unchanged; no alignment check. Sequential next = +4, wrapping at 2^DATA_WIDTH.
- IDLE (reset state). On the next edge, go to FETCH.
- FETCH: output empty. On ack: instr←rdata, pc←fetch_pc, instr_valid←1, fetch_pc←fetch_pc+4, go to PREFETCH.
- PREFETCH: output valid, prefetch outstanding.
  - Accept with PCsrc and ack: drop the word, fetch_pc←target, instr_valid←0, go to FETCH.
  - Accept with PCsrc, no ack: redirect_pc←target, instr_valid←0, go to DISCARD. fetch_pc is held for address stability.
  - Accept without PCsrc and ack: out regs←rdata/fetch_pc, fetch_pc+=4, stay in PREFETCH.
  - Accept without PCsrc, no ack: instr_valid←0, go to FETCH.
  - No accept, ack: skid←rdata/fetch_pc, fetch_pc+=4, go to HOLD.
- HOLD: output valid, skid full, no request.
  - Accept without PCsrc: out regs←skid, go to PREFETCH.
  - Accept with PCsrc: skid dropped, fetch_pc←target, instr_valid←0, go to FETCH.
- DISCARD: instr_valid=0. On ack: drop the word, fetch_pc←redirect_pc, go to FETCH.
- Out regs and skid regs change only as listed above. instr and pc hold their values while instr_valid=0.

## Timing
- Reset, async assert: state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=redirect_pc=RESET_PC, instr_valid=0, instr=0, pc=RESET_PC, skid=0.
- First rising edge after rst_n goes high: IDLE→FETCH, so imem_req=1 from that edge.
- With a zero-wait memory: first instr_valid comes 2 edges after reset release. With instr_ready held at 1, throughput is one instruction per cycle.
- Taken branch with the prefetch acked in the accept cycle: exactly 1 bubble cycle; the target is valid 2 cycles after the accept.
- Latency from ack to instr_valid is 1 cycle. All outputs are registered except imem_req, which decodes directly from state.
- rst_n asserted mid-transaction: all state clears immediately, and any in-flight ack is ignored. The memory must abandon the request on reset.

## Test plan
- Reset release, zero-wait memory (ack = req, rdata = addr ^ 32'hA5A5_0000), ready=1 → imem_addr 0,4,8,…; instr_valid from cycle 2; pc 0,4,8 on consecutive cycles, instr matching.
- Backpressure: ready=0 for 5 cycles after the first valid → state HOLD, imem_req=0 after the skid fills, pc stays 0. After release, pc 4 then 8 with no gap, no duplicates and no loss.
- Taken branch: accept pc=8 with PCsrc=1, ImmOp=32'hFFFF_FFF8 → next valid pc=0; the prefetched word for address 12 never appears; exactly 1 bubble.
- Branch during a slow fetch (ack 3 cycles late): accept pc=4 with PCsrc=1, ImmOp=32'h40 → imem_addr holds 8 until ack, then 32'h44; the returned word for 8 is dropped; next valid pc=32'h44.
- Wrap: RESET_PC=32'hFFFF_FFF8, sequential run → pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low while in DISCARD with a pending ack → outputs return to reset values asynchronously; after release the fetch restarts at RESET_PC, and the stale ack is not presented.
